// File: rtl/bp_stream_host_mmio.sv
// AXI4-Lite slave feeding 32b NBF flits into a FIFO that drives the stream loader.
// Optional BP_STREAM_HOST_MMIO_WCOUNT_EN adds a 32b popped-word counter at offset 0xC.
module bp_stream_host_mmio #(
  parameter int s_axil_addr_width_p = 32,
  parameter int s_axil_data_width_p = 32,
  parameter int stream_data_width_p = 32,
  parameter int fifo_els_p          = 16,
  parameter logic [s_axil_addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [s_axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [s_axil_data_width_p-1:0] s_axil_wdata_i,
  input  logic [3:0]                     s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [s_axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [s_axil_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  input  logic                           loader_done_i
);
  localparam int AW = s_axil_addr_width_p;
  localparam int DW = s_axil_data_width_p;
  localparam int PW = $clog2(fifo_els_p);
  localparam int CW = PW + 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake rule: a beat transfers on the rising edge where valid & ready are both 1.
  // Returns {hit, word index}; hit requires an aligned address inside the 16B window.
  function automatic logic [2:0] decode_addr(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - base_addr_p;
    return {(addr >= base_addr_p) && (off[AW-1:4] == '0) && (off[1:0] == 2'b00), off[3:2]};
  endfunction

  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr;
  logic [DW-1:0] w_data;
  logic [3:0]    w_strb;

  logic [stream_data_width_p-1:0] mem [fifo_els_p];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, flush;

  logic          wr_hit, wr_push_req, wr_flush_req, wr_go;
  logic [1:0]    wr_idx, wr_resp;
  logic          rd_hit;
  logic [1:0]    rd_idx, rd_resp_n;
  logic [DW-1:0] rd_data_n;

`ifdef BP_STREAM_HOST_MMIO_WCOUNT_EN
  logic [31:0]   wcount;
`endif

  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

  assign full  = (count == CW'(fifo_els_p));
  assign empty = (count == '0);
  assign stream_v_o    = ~empty;
  assign stream_data_o = mem[rd_ptr];
  assign pop = ~empty & stream_ready_i;

  assign s_axil_awready_o = ~aw_held;
  assign s_axil_wready_o  = ~w_held;
  assign s_axil_arready_o = ~s_axil_rvalid_o;

  always_comb begin
    {wr_hit, wr_idx} = decode_addr(aw_addr);
    wr_resp      = RESP_SLVERR;
    wr_push_req  = 1'b0;
    wr_flush_req = 1'b0;
    if (wr_hit) begin
      case (wr_idx)
        2'd0: if (w_strb == 4'hF) begin
          wr_resp     = RESP_OKAY;
          wr_push_req = 1'b1;
        end
        2'd2: begin
          wr_resp      = RESP_OKAY;
          wr_flush_req = w_data[0];
        end
        default: wr_resp = RESP_SLVERR;
      endcase
    end
  end

  // A valid DATA write waits here while the FIFO is full; it retries every cycle.
  assign wr_go = aw_held & w_held & ~s_axil_bvalid_o & ~(wr_push_req & full);
  assign push  = wr_go & wr_push_req;
  assign flush = wr_go & wr_flush_req;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_addr         <= '0;
      w_data          <= '0;
      w_strb          <= '0;
      s_axil_bvalid_o <= 1'b0;
      s_axil_bresp_o  <= RESP_OKAY;
    end else begin
      if (s_axil_awvalid_i && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= s_axil_awaddr_i;
      end
      if (s_axil_wvalid_i && !w_held) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata_i;
        w_strb <= s_axil_wstrb_i;
      end
      if (wr_go) begin
        s_axil_bvalid_o <= 1'b1;
        s_axil_bresp_o  <= wr_resp;
      end else if (s_axil_bvalid_o && s_axil_bready_i) begin
        s_axil_bvalid_o <= 1'b0;
        aw_held         <= 1'b0;
        w_held          <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= w_data;
  end

`ifdef BP_STREAM_HOST_MMIO_WCOUNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  wcount <= '0;
    else if (flush)  wcount <= '0;
    else if (pop)    wcount <= wcount + 32'd1;
  end
`endif

  always_comb begin
    {rd_hit, rd_idx} = decode_addr(s_axil_araddr_i);
    rd_data_n = '0;
    rd_resp_n = RESP_SLVERR;
    if (rd_hit) begin
      case (rd_idx)
        2'd0: rd_resp_n = RESP_OKAY;
        2'd1: begin
          rd_resp_n = RESP_OKAY;
          rd_data_n[CW+2:0] = {loader_done_i, full, empty, count};
        end
        2'd2: rd_resp_n = RESP_OKAY;
`ifdef BP_STREAM_HOST_MMIO_WCOUNT_EN
        2'd3: begin
          rd_resp_n = RESP_OKAY;
          rd_data_n = wcount;
        end
`else
        2'd3: rd_resp_n = RESP_SLVERR;
`endif
        default: rd_resp_n = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s_axil_rvalid_o <= 1'b0;
      s_axil_rdata_o  <= '0;
      s_axil_rresp_o  <= RESP_OKAY;
    end else if (s_axil_arvalid_i && !s_axil_rvalid_o) begin
      s_axil_rvalid_o <= 1'b1;
      s_axil_rdata_o  <= rd_data_n;
      s_axil_rresp_o  <= rd_resp_n;
    end else if (s_axil_rvalid_o && s_axil_rready_i) begin
      s_axil_rvalid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bp_stream_host_mmio.sv
// Self-checking bench for bp_stream_host_mmio: AXI-Lite driver tasks, stream scoreboard.
module tb_bp_stream_host_mmio;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_WCNT = BASE + 32'hC;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] s_axil_awaddr_i = '0;
  logic [2:0]  s_axil_awprot_i = '0;
  logic        s_axil_awvalid_i = 1'b0;
  logic        s_axil_awready_o;
  logic [31:0] s_axil_wdata_i = '0;
  logic [3:0]  s_axil_wstrb_i = '0;
  logic        s_axil_wvalid_i = 1'b0;
  logic        s_axil_wready_o;
  logic [1:0]  s_axil_bresp_o;
  logic        s_axil_bvalid_o;
  logic        s_axil_bready_i = 1'b0;
  logic [31:0] s_axil_araddr_i = '0;
  logic [2:0]  s_axil_arprot_i = '0;
  logic        s_axil_arvalid_i = 1'b0;
  logic        s_axil_arready_o;
  logic [31:0] s_axil_rdata_o;
  logic [1:0]  s_axil_rresp_o;
  logic        s_axil_rvalid_o;
  logic        s_axil_rready_i = 1'b0;
  logic        stream_v_o;
  logic [31:0] stream_data_o;
  logic        stream_ready_i = 1'b0;
  logic        loader_done_i = 1'b0;

  bp_stream_host_mmio #(.base_addr_p(BASE)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .s_axil_awaddr_i(s_axil_awaddr_i), .s_axil_awprot_i(s_axil_awprot_i),
    .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
    .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i),
    .s_axil_wvalid_i(s_axil_wvalid_i), .s_axil_wready_o(s_axil_wready_o),
    .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
    .s_axil_bready_i(s_axil_bready_i),
    .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arprot_i(s_axil_arprot_i),
    .s_axil_arvalid_i(s_axil_arvalid_i), .s_axil_arready_o(s_axil_arready_o),
    .s_axil_rdata_o(s_axil_rdata_o), .s_axil_rresp_o(s_axil_rresp_o),
    .s_axil_rvalid_o(s_axil_rvalid_o), .s_axil_rready_i(s_axil_rready_i),
    .stream_v_o(stream_v_o), .stream_data_o(stream_data_o),
    .stream_ready_i(stream_ready_i), .loader_done_i(loader_done_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] status_exp(input logic done, input logic fl, input logic em,
                                             input int cnt);
    logic [4:0] c;
    c = cnt[4:0];
    return {24'h0, done, fl, em, c};
  endfunction

  // Stream scoreboard: every word leaving the FIFO must match the oldest expected word.
  always @(negedge clk_i) begin
    if (reset_n_i && stream_v_o && stream_ready_i) begin
      if (exp_q.size() == 0) check("stream_unexpected_pop", stream_data_o, 32'hxxxx_xxxx);
      else check("stream_data", stream_data_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int cyc = 0;
    resp = 2'b11;
    s_axil_bready_i = 1'b1;
    while (!b_done && cyc < 300) begin
      s_axil_awvalid_i = !aw_done && (cyc >= aw_dly);
      s_axil_awaddr_i  = addr;
      s_axil_wvalid_i  = !w_done && (cyc >= w_dly);
      s_axil_wdata_i   = data;
      s_axil_wstrb_i   = strb;
      @(negedge clk_i);
      if (s_axil_awvalid_i && s_axil_awready_o) aw_done = 1;
      if (s_axil_wvalid_i && s_axil_wready_o) w_done = 1;
      if (s_axil_bvalid_o) begin
        b_done = 1;
        resp = s_axil_bresp_o;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_bready_i  = 1'b0;
    if (!b_done) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    int cyc = 0;
    data = '0;
    resp = 2'b11;
    while (!ar_done && cyc < 100) begin
      s_axil_arvalid_i = 1'b1;
      s_axil_araddr_i  = addr;
      @(negedge clk_i);
      if (s_axil_arready_o) ar_done = 1;
      @(posedge clk_i); #1;
      cyc++;
    end
    s_axil_arvalid_i = 1'b0;
    s_axil_rready_i  = 1'b1;
    while (!r_done && cyc < 200) begin
      @(negedge clk_i);
      if (s_axil_rvalid_o) begin
        r_done = 1;
        data = s_axil_rdata_o;
        resp = s_axil_rresp_o;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    s_axil_rready_i = 1'b0;
    if (!r_done) check("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] data, input string tag);
    logic [1:0] r;
    exp_q.push_back(data);
    axi_write(A_DATA, data, 4'hF, 0, 0, r);
    check(tag, {30'd0, r}, {30'd0, OKAY});
  endtask

  task automatic drain();
    int cyc = 0;
    stream_ready_i = 1'b1;
    while (stream_v_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    stream_ready_i = 1'b0;
    check("drain_done", {31'd0, stream_v_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    logic [31:0] words [3];
    bit saw_b;

    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: reset state
    check("rst_stream_v", {31'd0, stream_v_o}, 32'd0);
    check("rst_awready", {31'd0, s_axil_awready_o}, 32'd1);
    check("rst_bvalid", {31'd0, s_axil_bvalid_o}, 32'd0);
    axi_read(A_STAT, rd, rr);
    check("rst_status", rd, status_exp(0, 0, 1, 0));
    check("rst_status_resp", {30'd0, rr}, {30'd0, OKAY});

    // 2: two words straight through with the loader ready
    stream_ready_i = 1'b1;
    push_word(32'h0000_0002, "t2_bresp0");
    push_word(32'hDEAD_BEEF, "t2_bresp1");
    repeat (3) @(posedge clk_i); #1;
    stream_ready_i = 1'b0;
    check("t2_queue_empty", exp_q.size(), 32'd0);
`ifdef BP_STREAM_HOST_MMIO_WCOUNT_EN
    axi_read(A_WCNT, rd, rr);
    check("t2_wcount", rd, 32'd2);
    check("t2_wcount_resp", {30'd0, rr}, {30'd0, OKAY});
`else
    axi_read(A_WCNT, rd, rr);
    check("t2_wcount_slverr", {30'd0, rr}, {30'd0, SLVERR});
`endif

    // 3: fill to full, then a stalled 17th write
    for (int i = 0; i < 16; i++) push_word($urandom(), "t3_fill_bresp");
    axi_read(A_STAT, rd, rr);
    check("t3_status_full", rd, status_exp(0, 1, 0, 16));
    saw_b = 0;
    fork
      begin
        exp_q.push_back(32'hCAFE_0017);
        axi_write(A_DATA, 32'hCAFE_0017, 4'hF, 0, 0, br);
      end
      begin
        repeat (12) begin
          @(negedge clk_i);
          if (s_axil_bvalid_o) saw_b = 1;
        end
        @(posedge clk_i); #1;
        stream_ready_i = 1'b1;
        @(posedge clk_i); #1;
        stream_ready_i = 1'b0;
      end
    join
    check("t3_no_b_while_full", {31'd0, saw_b}, 32'd0);
    check("t3_stalled_bresp", {30'd0, br}, {30'd0, OKAY});
    loader_done_i = 1'b1;
    axi_read(A_STAT, rd, rr);
    check("t3_status_after", rd, status_exp(1, 1, 0, 16));
    loader_done_i = 1'b0;
    drain();

    // 4: W ahead of AW and AW ahead of W
    stream_ready_i = 1'b1;
    exp_q.push_back(32'h1111_AAAA);
    axi_write(A_DATA, 32'h1111_AAAA, 4'hF, 3, 0, br);
    check("t4_w_first_bresp", {30'd0, br}, {30'd0, OKAY});
    exp_q.push_back(32'h2222_BBBB);
    axi_write(A_DATA, 32'h2222_BBBB, 4'hF, 0, 3, br);
    check("t4_aw_first_bresp", {30'd0, br}, {30'd0, OKAY});
    repeat (3) @(posedge clk_i); #1;
    stream_ready_i = 1'b0;
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: error responses leave the FIFO untouched
    push_word(32'h5555_0001, "t5_seed_bresp");
    axi_write(A_DATA, 32'hBAD0_0001, 4'h3, 0, 0, br);
    check("t5_partial_strb", {30'd0, br}, {30'd0, SLVERR});
    axi_write(BASE + 32'h20, 32'hBAD0_0002, 4'hF, 0, 0, br);
    check("t5_out_of_range", {30'd0, br}, {30'd0, SLVERR});
    axi_write(BASE + 32'h2, 32'hBAD0_0003, 4'hF, 0, 0, br);
    check("t5_misaligned", {30'd0, br}, {30'd0, SLVERR});
    axi_write(A_STAT, 32'h0, 4'hF, 0, 0, br);
    check("t5_status_write", {30'd0, br}, {30'd0, SLVERR});
    axi_read(BASE - 32'h4, rd, rr);
    check("t5_read_below_base", {30'd0, rr}, {30'd0, SLVERR});
    axi_read(A_STAT, rd, rr);
    check("t5_count_unchanged", rd, status_exp(0, 0, 0, 1));
    axi_read(A_DATA, rd, rr);
    check("t5_data_read_zero", rd, 32'd0);
    drain();

    // 6: flush with the loader ready, then reset in the middle of traffic
    for (int i = 0; i < 5; i++) push_word(32'hF000_0000 + 32'(i), "t6_fill_bresp");
    axi_read(A_STAT, rd, rr);
    check("t6_count5", rd, status_exp(0, 0, 0, 5));
    stream_ready_i = 1'b1;
    axi_write(A_CTRL, 32'h1, 4'hF, 0, 0, br);
    check("t6_flush_bresp", {30'd0, br}, {30'd0, OKAY});
    @(negedge clk_i);
    check("t6_stream_v_after_flush", {31'd0, stream_v_o}, 32'd0);
    @(posedge clk_i); #1;
    stream_ready_i = 1'b0;
    exp_q.delete();
    axi_read(A_STAT, rd, rr);
    check("t6_status_flushed", rd, status_exp(0, 0, 1, 0));
`ifdef BP_STREAM_HOST_MMIO_WCOUNT_EN
    axi_read(A_WCNT, rd, rr);
    check("t6_wcount_cleared", rd, 32'd0);
`endif

    for (int i = 0; i < 3; i++) words[i] = $urandom_range(32'h0, 32'hFFFF);
    for (int i = 0; i < 3; i++) push_word(words[i], "t6_burst_bresp");
    s_axil_awvalid_i = 1'b1;
    s_axil_awaddr_i  = A_DATA;
    s_axil_arvalid_i = 1'b1;
    s_axil_araddr_i  = A_STAT;
    @(posedge clk_i); #1;
    s_axil_awvalid_i = 1'b0;
    s_axil_arvalid_i = 1'b0;
    check("t6_aw_in_flight", {31'd0, s_axil_awready_o}, 32'd0);
    check("t6_r_pending", {31'd0, s_axil_rvalid_o}, 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check("t6_rst_awready", {31'd0, s_axil_awready_o}, 32'd1);
    check("t6_rst_wready", {31'd0, s_axil_wready_o}, 32'd1);
    check("t6_rst_arready", {31'd0, s_axil_arready_o}, 32'd1);
    check("t6_rst_bvalid", {31'd0, s_axil_bvalid_o}, 32'd0);
    check("t6_rst_rvalid", {31'd0, s_axil_rvalid_o}, 32'd0);
    check("t6_rst_rdata", s_axil_rdata_o, 32'd0);
    check("t6_rst_resps", {28'd0, s_axil_bresp_o, s_axil_rresp_o}, 32'd0);
    check("t6_rst_stream_v", {31'd0, stream_v_o}, 32'd0);
    exp_q.delete();
    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    axi_read(A_STAT, rd, rr);
    check("t6_status_post_reset", rd, status_exp(0, 0, 1, 0));

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
